// File: rtl/life_array_16x16.sv
// 16x16 Conway B3/S23 cell array with row write/readback, previous-generation
// shadow, and edge/corner I/O so arrays can be tiled into a larger board.
module life_array_16x16 (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] vali,
  input  logic [3:0]  vali_selector,
  input  logic [3:0]  valo_selector,
  input  logic        write_enb,
  input  logic        step,
  output logic [15:0] valo,
  output logic [15:0] valo_prev,
  input  logic [15:0] ni,
  input  logic [15:0] si,
  input  logic [15:0] wi,
  input  logic [15:0] ei,
  input  logic        nwi,
  input  logic        nei,
  input  logic        sei,
  input  logic        swi,
  output logic [15:0] no,
  output logic [15:0] so,
  output logic [15:0] wo,
  output logic [15:0] eo,
  output logic        nwo,
  output logic        neo,
  output logic        seo,
  output logic        swo
);

  logic [15:0] r_cell [16];
  logic [15:0] r_prev [16];
  logic [17:0] w_pad  [18];
  logic [15:0] w_next [16];

  // Padded grid: row 0 / 17 and bit 0 / 17 carry the neighbours outside the array.
  always_comb begin
    w_pad[0]  = {nei, ni, nwi};
    w_pad[17] = {sei, si, swi};
    for (int r = 0; r < 16; r++) begin
      w_pad[r+1] = {ei[r], r_cell[r], wi[r]};
    end
  end

  always_comb begin
    logic [3:0] cnt;
    for (int r = 0; r < 16; r++) begin
      w_next[r] = '0;
      for (int c = 0; c < 16; c++) begin
        cnt = '0;
        for (int dr = 0; dr < 3; dr++) begin
          for (int dc = 0; dc < 3; dc++) begin
            if (!(dr == 1 && dc == 1)) begin
              cnt = cnt + 4'(w_pad[r+dr][c+dc]);
            end
          end
        end
        w_next[r][c] = (cnt == 4'd3) || (r_cell[r][c] && cnt == 4'd2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int r = 0; r < 16; r++) begin
        r_cell[r] <= '0;
        r_prev[r] <= '0;
      end
    end else if (write_enb) begin
      r_cell[vali_selector] <= vali;
    end else if (step) begin
      for (int r = 0; r < 16; r++) begin
        r_cell[r] <= w_next[r];
        r_prev[r] <= r_cell[r];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 16; r++) begin
      wo[r] = r_cell[r][0];
      eo[r] = r_cell[r][15];
    end
  end

  assign valo      = r_cell[valo_selector];
  assign valo_prev = r_prev[valo_selector];
  assign no        = r_cell[0];
  assign so        = r_cell[15];
  assign nwo       = r_cell[0][0];
  assign neo       = r_cell[0][15];
  assign seo       = r_cell[15][15];
  assign swo       = r_cell[15][0];

endmodule

// File: tb/tb_life_array_16x16.sv
// Bench for life_array_16x16: directed vector table, hand sequences for reset
// and edge outputs, and randomized traffic against a cell-level Life model.
module tb_life_array_16x16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] vali;
  logic [3:0]  vali_selector, valo_selector;
  logic        write_enb, step;
  logic [15:0] valo, valo_prev;
  logic [15:0] ni, si, wi, ei;
  logic        nwi, nei, sei, swi;
  logic [15:0] no, so, wo, eo;
  logic        nwo, neo, seo, swo;

  always #50 clk = ~clk;

  life_array_16x16 dut (
    .clk(clk), .reset(reset), .vali(vali), .vali_selector(vali_selector),
    .valo_selector(valo_selector), .write_enb(write_enb), .step(step),
    .valo(valo), .valo_prev(valo_prev),
    .ni(ni), .si(si), .wi(wi), .ei(ei),
    .nwi(nwi), .nei(nei), .sei(sei), .swi(swi),
    .no(no), .so(so), .wo(wo), .eo(eo),
    .nwo(nwo), .neo(neo), .seo(seo), .swo(swo)
  );

  typedef struct {
    logic        rst_n;
    logic        we;
    logic        st;
    logic [3:0]  wsel;
    logic [15:0] wdata;
    logic [15:0] n_in;
    logic [3:0]  rsel;
    logic [15:0] exp_valo;
    logic [15:0] exp_prev;
  } vec_t;

  vec_t vq[$];

  bit m_cell [16][16];
  bit m_prev [16][16];
  int n_pass  = 0;
  int n_total = 0;

  function automatic vec_t mk(logic rst_n, logic we, logic st, logic [3:0] wsel,
                              logic [15:0] wdata, logic [15:0] n_in, logic [3:0] rsel,
                              logic [15:0] ev, logic [15:0] ep);
    vec_t v;
    v.rst_n = rst_n; v.we = we; v.st = st; v.wsel = wsel; v.wdata = wdata;
    v.n_in = n_in; v.rsel = rsel; v.exp_valo = ev; v.exp_prev = ep;
    return v;
  endfunction

  // Cell value at (r,c), with positions outside the array taken from the boundary inputs.
  function automatic bit at(int r, int c);
    if (r < 0)  return (c < 0) ? nwi : (c > 15) ? nei : ni[c];
    if (r > 15) return (c < 0) ? swi : (c > 15) ? sei : si[c];
    if (c < 0)  return wi[r];
    if (c > 15) return ei[r];
    return m_cell[r][c];
  endfunction

  function automatic logic [15:0] mrow(int r, bit use_prev);
    logic [15:0] v;
    for (int c = 0; c < 16; c++) v[c] = use_prev ? m_prev[r][c] : m_cell[r][c];
    return v;
  endfunction

  function automatic logic [15:0] mcol(int c);
    logic [15:0] v;
    for (int r = 0; r < 16; r++) v[r] = m_cell[r][c];
    return v;
  endfunction

  task automatic model_edge();
    bit nx [16][16];
    int n;
    if (!reset) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          m_cell[r][c] = 1'b0;
          m_prev[r][c] = 1'b0;
        end
    end else if (write_enb) begin
      for (int c = 0; c < 16; c++) m_cell[vali_selector][c] = vali[c];
    end else if (step) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++) begin
          n = 0;
          for (int dr = -1; dr <= 1; dr++)
            for (int dc = -1; dc <= 1; dc++)
              if (dr != 0 || dc != 0) n += int'(at(r + dr, c + dc));
          nx[r][c] = (n == 3) || (m_cell[r][c] && n == 2);
        end
      m_prev = m_cell;
      m_cell = nx;
    end
  endtask

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    reset = 1'b1; write_enb = 1'b0; step = 1'b0;
  endtask

  task automatic check_all(string tag);
    for (int r = 0; r < 16; r++) begin
      valo_selector = 4'(r);
      #1;
      chk($sformatf("%s valo[%0d]", tag, r), valo, mrow(r, 1'b0));
      chk($sformatf("%s prev[%0d]", tag, r), valo_prev, mrow(r, 1'b1));
    end
    chk({tag, " no"}, no, mrow(0, 1'b0));
    chk({tag, " so"}, so, mrow(15, 1'b0));
    chk({tag, " wo"}, wo, mcol(0));
    chk({tag, " eo"}, eo, mcol(15));
    chk({tag, " corners"}, {12'h0, nwo, neo, seo, swo},
        {12'h0, m_cell[0][0], m_cell[0][15], m_cell[15][15], m_cell[15][0]});
  endtask

  initial begin
    reset = 1'b0; write_enb = 1'b0; step = 1'b0;
    vali = '0; vali_selector = '0; valo_selector = '0;
    ni = '0; si = '0; wi = '0; ei = '0;
    nwi = 1'b0; nei = 1'b0; sei = 1'b0; swi = 1'b0;

    // rst_n we st wsel wdata ni rsel exp_valo exp_prev
    vq.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(1, 1, 0, 0, 16'h0001, 16'h0000, 0, 16'h0001, 16'h0000));
    vq.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 1, 0, 2, 16'hFFFF, 16'h0000, 2, 16'h0000, 16'h0000));
    vq.push_back(mk(1, 1, 0, 5, 16'h0070, 16'h0000, 5, 16'h0070, 16'h0000));
    vq.push_back(mk(1, 0, 1, 0, 16'h0000, 16'h0000, 5, 16'h0020, 16'h0070));
    vq.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 4, 16'h0020, 16'h0000));
    vq.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 6, 16'h0020, 16'h0000));
    vq.push_back(mk(1, 0, 1, 0, 16'h0000, 16'h0000, 5, 16'h0070, 16'h0020));
    vq.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 4, 16'h0000, 16'h0020));
    vq.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 6, 16'h0000, 16'h0020));
    vq.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 5, 16'h0000, 16'h0000));
    vq.push_back(mk(1, 1, 0, 7, 16'h0180, 16'h0000, 7, 16'h0180, 16'h0000));
    vq.push_back(mk(1, 1, 0, 8, 16'h0180, 16'h0000, 8, 16'h0180, 16'h0000));
    vq.push_back(mk(1, 0, 1, 0, 16'h0000, 16'h0000, 7, 16'h0180, 16'h0180));
    vq.push_back(mk(1, 0, 1, 0, 16'h0000, 16'h0000, 8, 16'h0180, 16'h0180));
    vq.push_back(mk(1, 0, 1, 0, 16'h0000, 16'h0000, 7, 16'h0180, 16'h0180));
    vq.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 6, 16'h0000, 16'h0000));
    vq.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 9, 16'h0000, 16'h0000));
    vq.push_back(mk(0, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000, 16'h0000));
    vq.push_back(mk(1, 0, 1, 0, 16'h0000, 16'h0007, 0, 16'h0002, 16'h0000));
    vq.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 1, 16'h0000, 16'h0000));
    vq.push_back(mk(1, 1, 1, 3, 16'hFFFF, 16'h0000, 3, 16'hFFFF, 16'h0000));
    vq.push_back(mk(1, 0, 0, 0, 16'h0000, 16'h0000, 0, 16'h0002, 16'h0000));

    #1;
    foreach (vq[i]) begin
      reset = vq[i].rst_n; write_enb = vq[i].we; step = vq[i].st;
      vali_selector = vq[i].wsel; vali = vq[i].wdata; ni = vq[i].n_in;
      clk_edge();
      idle();
      ni = '0;
      valo_selector = vq[i].rsel;
      #1;
      chk($sformatf("vec%0d valo", i), valo, vq[i].exp_valo);
      chk($sformatf("vec%0d valo_prev", i), valo_prev, vq[i].exp_prev);
    end

    // Single live cell in the NW corner drives every output that touches (0,0).
    reset = 1'b0;
    clk_edge();
    idle();
    write_enb = 1'b1; vali_selector = 4'd0; vali = 16'h0001;
    clk_edge();
    idle();
    #1;
    chk("corner nwo", {15'h0, nwo}, 16'h0001);
    chk("corner no", no, 16'h0001);
    chk("corner wo", wo, 16'h0001);
    check_all("corner");

    // Randomized traffic with random boundary inputs.
    for (int k = 0; k < 300; k++) begin
      reset     = ($urandom_range(0, 99) != 0);
      write_enb = ($urandom_range(0, 3) == 0) || (k < 16);
      step      = $urandom_range(0, 1) == 1;
      vali_selector = 4'($urandom_range(0, 15));
      vali      = 16'($urandom);
      ni = 16'($urandom); si = 16'($urandom); wi = 16'($urandom); ei = 16'($urandom);
      {nwi, nei, sei, swi} = 4'($urandom);
      clk_edge();
      idle();
      check_all("rand");
    end

    // Populate, assert reset between edges: state must hold until the next edge.
    ni = '0; si = '0; wi = '0; ei = '0;
    {nwi, nei, sei, swi} = 4'h0;
    for (int r = 0; r < 16; r++) begin
      write_enb = 1'b1; vali_selector = 4'(r); vali = 16'($urandom) | 16'h8001;
      clk_edge();
    end
    idle();
    step = 1'b1;
    clk_edge();
    idle();
    for (int r = 0; r < 16; r++) begin
      write_enb = 1'b1; vali_selector = 4'(r); vali = 16'($urandom) | 16'h8001;
      clk_edge();
    end
    idle();
    reset = 1'b0;
    #20;
    check_all("pre_reset_edge");
    write_enb = 1'b1; step = 1'b1; vali_selector = 4'd4; vali = 16'hFFFF;
    clk_edge();
    idle();
    check_all("post_reset");
    chk("post_reset no_so", no | so, 16'h0000);
    chk("post_reset wo_eo", wo | eo, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
